// File: rtl/ps2_key_state.sv
// ps2_key_state
//   Turns the raw PS/2 set-2 byte stream into held-key levels for the player
//   movement block. Make/break and E0-prefixed sequences are decoded, the held
//   state of each key is tracked, and the direction levels are re-sampled only
//   on startOfFrame so the movement FSM sees inputs that are constant for a
//   whole frame.
//
//   Ports:
//     clk             system clock
//     resetN          asynchronous active-low reset
//     byte_valid      one-cycle strobe, byte_in carries a new received byte
//     byte_in[7:0]    received scan byte
//     rx_error        receiver error / focus loss, drops every held key
//     startOfFrame    frame start pulse, updates the outputs
//     key_up/down/left/right  frame-latched held levels
//     key_enter_pulse one-cycle pulse at frame start if Enter was pressed
//                     since the previous frame
module ps2_key_state #(
    parameter int ENABLE_WASD    = 1,
    parameter int PREFIX_TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    input  logic       rx_error,
    input  logic       startOfFrame,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic       key_enter_pulse
);

    localparam int               CNT_W    = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);
    localparam logic             WASD_EN  = (ENABLE_WASD != 0);

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE_ST    = 2'd0,
        EXT_ST     = 2'd1,
        BRK_ST     = 2'd2,
        EXT_BRK_ST = 2'd3
    } state_t;

    // held bit layout: 0 up, 1 down, 2 left, 3 right (arrows), 4 W, 5 S, 6 A, 7 D
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       held_q, held_d;
    logic             enter_seen_q, enter_seen_d;
    logic             key_up_q, key_up_d;
    logic             key_down_q, key_down_d;
    logic             key_left_q, key_left_d;
    logic             key_right_q, key_right_d;
    logic             key_enter_pulse_q, key_enter_pulse_d;

    // Decoded meaning of the current byte
    logic       is_make;
    logic       is_break;
    logic       is_ext;
    logic       code_hit;
    logic [2:0] code_idx;
    logic       code_enter;

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        held_d            = held_q;
        enter_seen_d      = enter_seen_q;
        key_up_d          = key_up_q;
        key_down_d        = key_down_q;
        key_left_d        = key_left_q;
        key_right_d       = key_right_q;
        key_enter_pulse_d = 1'b0;
        is_make           = 1'b0;
        is_break          = 1'b0;
        is_ext            = 1'b0;
        code_hit          = 1'b0;
        code_idx          = 3'd0;
        code_enter        = 1'b0;

        // Frame latch samples the registered held bits, so a byte arriving in
        // the same cycle only shows up at the following frame.
        if (startOfFrame) begin
            key_up_d          = held_q[0] | (WASD_EN & held_q[4]);
            key_down_d        = held_q[1] | (WASD_EN & held_q[5]);
            key_left_d        = held_q[2] | (WASD_EN & held_q[6]);
            key_right_d       = held_q[3] | (WASD_EN & held_q[7]);
            key_enter_pulse_d = enter_seen_q;
            enter_seen_d      = 1'b0;
        end

        if (rx_error) begin
            // Error dominates a coincident byte, which is simply dropped.
            state_d      = IDLE_ST;
            cnt_d        = '0;
            held_d       = '0;
            enter_seen_d = 1'b0;
        end else if (byte_valid) begin
            cnt_d = '0;
            unique case (state_q)
                IDLE_ST: begin
                    if (byte_in == PFX_EXT)      state_d = EXT_ST;
                    else if (byte_in == PFX_BRK) state_d = BRK_ST;
                    else                         is_make = 1'b1;
                end
                EXT_ST: begin
                    if (byte_in == PFX_BRK)      state_d = EXT_BRK_ST;
                    else if (byte_in != PFX_EXT) begin
                        is_make = 1'b1;
                        is_ext  = 1'b1;
                        state_d = IDLE_ST;
                    end
                end
                BRK_ST: begin
                    if (byte_in == PFX_EXT)      state_d = EXT_ST;
                    else if (byte_in != PFX_BRK) begin
                        is_break = 1'b1;
                        state_d  = IDLE_ST;
                    end
                end
                EXT_BRK_ST: begin
                    if (byte_in == PFX_EXT)      state_d = EXT_ST;
                    else if (byte_in == PFX_BRK) state_d = BRK_ST;
                    else begin
                        is_break = 1'b1;
                        is_ext   = 1'b1;
                        state_d  = IDLE_ST;
                    end
                end
                default: state_d = IDLE_ST;
            endcase

            if (is_ext) begin
                case (byte_in)
                    8'h75:   begin code_hit = 1'b1; code_idx = 3'd0; end
                    8'h72:   begin code_hit = 1'b1; code_idx = 3'd1; end
                    8'h6B:   begin code_hit = 1'b1; code_idx = 3'd2; end
                    8'h74:   begin code_hit = 1'b1; code_idx = 3'd3; end
                    default: code_hit = 1'b0;
                endcase
            end else begin
                case (byte_in)
                    8'h1D:   begin code_hit = WASD_EN; code_idx = 3'd4; end
                    8'h1B:   begin code_hit = WASD_EN; code_idx = 3'd5; end
                    8'h1C:   begin code_hit = WASD_EN; code_idx = 3'd6; end
                    8'h23:   begin code_hit = WASD_EN; code_idx = 3'd7; end
                    8'h5A:   code_enter = 1'b1;
                    default: code_hit = 1'b0;
                endcase
            end

            // Repeat makes and breaks of unheld keys fall out as no-ops.
            if (code_hit && (is_make || is_break)) begin
                held_d[code_idx] = is_make;
            end
            // Applied after the frame clear so a coincident Enter make survives.
            if (code_enter && is_make) begin
                enter_seen_d = 1'b1;
            end
        end else if (state_q != IDLE_ST) begin
            if (cnt_q == CNT_LAST) begin
                state_d = IDLE_ST;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q           <= IDLE_ST;
            cnt_q             <= '0;
            held_q            <= '0;
            enter_seen_q      <= 1'b0;
            key_up_q          <= 1'b0;
            key_down_q        <= 1'b0;
            key_left_q        <= 1'b0;
            key_right_q       <= 1'b0;
            key_enter_pulse_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            held_q            <= held_d;
            enter_seen_q      <= enter_seen_d;
            key_up_q          <= key_up_d;
            key_down_q        <= key_down_d;
            key_left_q        <= key_left_d;
            key_right_q       <= key_right_d;
            key_enter_pulse_q <= key_enter_pulse_d;
        end
    end

    assign key_up          = key_up_q;
    assign key_down        = key_down_q;
    assign key_left        = key_left_q;
    assign key_right       = key_right_q;
    assign key_enter_pulse = key_enter_pulse_q;

endmodule

// File: tb/tb_ps2_key_state.sv
// Bench for ps2_key_state: one instance with WASD aliasing, one without.
// Each startOfFrame pushes the hand-derived expected outputs of both
// instances; a monitor pops and compares on the cycle the outputs update.
module tb_ps2_key_state;

    localparam int P = 20;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       rx_error = 1'b0;
    logic       startOfFrame = 1'b0;

    logic w_up, w_down, w_left, w_right, w_ent;
    logic n_up, n_down, n_left, n_right, n_ent;

    int vectors = 0;
    int miscompares = 0;
    int sof_num = 0;

    logic [9:0] exp_q[$];
    logic       sof_prev = 1'b0;
    logic       pulse_chk = 1'b0;

    ps2_key_state #(.ENABLE_WASD(1), .PREFIX_TIMEOUT(P)) u_wasd (
        .clk(clk), .resetN(resetN), .byte_valid(byte_valid), .byte_in(byte_in),
        .rx_error(rx_error), .startOfFrame(startOfFrame),
        .key_up(w_up), .key_down(w_down), .key_left(w_left), .key_right(w_right),
        .key_enter_pulse(w_ent)
    );

    ps2_key_state #(.ENABLE_WASD(0), .PREFIX_TIMEOUT(P)) u_nowasd (
        .clk(clk), .resetN(resetN), .byte_valid(byte_valid), .byte_in(byte_in),
        .rx_error(rx_error), .startOfFrame(startOfFrame),
        .key_up(n_up), .key_down(n_down), .key_left(n_left), .key_right(n_right),
        .key_enter_pulse(n_ent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [4:0] act, input logic [4:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s #%0d: got udlre=%b expected udlre=%b", name, idx, act, exp);
        end
    endtask

    // Monitor: outputs are valid on the negedge after a sampled startOfFrame.
    always @(posedge clk) sof_prev <= startOfFrame;

    always @(negedge clk) begin
        logic [9:0] e;
        if (sof_prev) begin
            sof_num++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sof_unexpected #%0d: no expected entry queued", sof_num);
            end else begin
                e = exp_q.pop_front();
                chk("frame_wasd", sof_num, {w_up, w_down, w_left, w_right, w_ent}, e[9:5]);
                chk("frame_nowasd", sof_num, {n_up, n_down, n_left, n_right, n_ent}, e[4:0]);
            end
            pulse_chk <= 1'b1;
        end else if (pulse_chk) begin
            chk("pulse_end_wasd", sof_num, {4'b0000, w_ent}, 5'b00000);
            chk("pulse_end_nowasd", sof_num, {4'b0000, n_ent}, 5'b00000);
            pulse_chk <= 1'b0;
        end
    end

    // All stimulus tasks start and end on a negedge.
    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic sof(input logic [4:0] e_w, input logic [4:0] e_n);
        exp_q.push_back({e_w, e_n});
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_sof(input logic [7:0] b, input logic [4:0] e_w, input logic [4:0] e_n);
        exp_q.push_back({e_w, e_n});
        startOfFrame = 1'b1;
        byte_valid   = 1'b1;
        byte_in      = b;
        @(negedge clk);
        startOfFrame = 1'b0;
        byte_valid   = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_direct(input string name);
        chk({name, "_wasd"}, 0, {w_up, w_down, w_left, w_right, w_ent}, 5'b00000);
        chk({name, "_nowasd"}, 0, {n_up, n_down, n_left, n_right, n_ent}, 5'b00000);
    endtask

    initial begin
        #3 resetN = 1'b0;
        #3 chk_direct("reset");
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        // Extended up make / break
        send(8'hE0); send(8'h75);
        sof(5'b10000, 5'b10000);
        send(8'hE0); send(8'hF0); send(8'h75);
        sof(5'b00000, 5'b00000);

        // W held keeps up asserted after the arrow is released
        send(8'h1D);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        sof(5'b10000, 5'b00000);
        send(8'hF0); send(8'h1D);
        sof(5'b00000, 5'b00000);

        // Enter: repeats, break does not cancel, pulse lasts one frame
        send(8'h5A); send(8'h5A); send(8'hF0); send(8'h5A);
        sof(5'b00001, 5'b00001);
        sof(5'b00000, 5'b00000);

        // Prefix timeout: P-1 idle cycles keep the prefix, P idle cycles drop it
        send(8'hE0);
        repeat (P - 1) @(negedge clk);
        send(8'h74);
        sof(5'b00010, 5'b00010);
        send(8'hE0); send(8'hF0); send(8'h74);
        sof(5'b00000, 5'b00000);
        send(8'hE0);
        repeat (P) @(negedge clk);
        send(8'h74);
        sof(5'b00000, 5'b00000);

        // Left and right together, then rx_error wipes everything
        send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'h74);
        sof(5'b00110, 5'b00110);
        send(8'h5A);
        rx_error = 1'b1;
        send(8'hE0);
        rx_error = 1'b0;
        send(8'h75);
        sof(5'b00000, 5'b00000);

        // Byte coinciding with startOfFrame lands one frame later
        send(8'hE0);
        send_sof(8'h72, 5'b00000, 5'b00000);
        sof(5'b01000, 5'b01000);
        send_sof(8'h5A, 5'b01000, 5'b01000);
        sof(5'b01001, 5'b01001);
        send(8'hE0); send(8'hF0); send(8'h72);
        sof(5'b00000, 5'b00000);

        // Reset in the middle of a break sequence
        send(8'hE0); send(8'h75);
        sof(5'b10000, 5'b10000);
        send(8'hE0); send(8'hF0);
        resetN = 1'b0;
        #1 chk_direct("midreset");
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        send(8'h75);
        sof(5'b00000, 5'b00000);

        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d pending frames expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
